det_count_display: RTL and testbench
====================================

Name: det_count_display

Overview:
- Downstream consumer of the sequence detector's `detected` output.
- Counts detection events on a 4-digit BCD counter and shows the count on the board's multiplexed 4-digit seven-segment display.
- Runs on the board clock CLK. `detected` comes from the divided-clock detector domain, so it is synchronised and edge-detected here.
- Provides a sticky overflow flag and a clear input driven by a board switch.

Parameters:
- REFRESH_DIV, 100000, CLK cycles per displayed digit (1 kHz digit rate at 100 MHz). Benches use 4. Legal range 2 to 2^20.

Ports:
- CLK  input  1  board clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- detected  input  1  detector output, asynchronous to CLK.
- CLR  input  1  synchronous clear of count and OVF, active high. Already synchronised by its source.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active low.
- DP  output  1  decimal point, active low. Tied off (1) except as defined below.
- AN  output  4  digit anodes, active-low one-hot; AN[0] is the least significant digit.
- OVF  output  1  sticky overflow flag.

Behaviour:
- Reset (RST_N low): asynchronous and immediate.
  - Clears sync flops, count (0000), OVF=0, refresh counter=0, digit index=0.
  - Outputs: AN=1110, SEG=1000000 (shows "0"), DP=1.
- Synchroniser: two flops, s1 then s2, followed by a history flop s3.
  - inc = s2 & ~s3, a one-cycle pulse.
  - If `detected` is first sampled high at edge k, count shows the new value after edge k+2.
  - `detected` must stay high at least 2 CLK cycles and low at least 2 CLK cycles between events. A level held high for any length is exactly one event.
- Counter: four BCD digits d3..d0, each 0-9, ripple-carry on inc.
  - 9999 + inc gives 0000 and sets OVF=1 on the same edge.
  - OVF stays set until CLR or reset.
  - CLR high at an edge: count=0000, OVF=0. CLR has priority over a simultaneous inc; that event is lost.
  - A wrap and a CLR in the same cycle give OVF=0.
- Scan:
  - The refresh counter runs 0..REFRESH_DIV-1.
  - At terminal count it returns to 0 and the digit index advances 0,1,2,3,0,...
  - AN = ~(1 << index); sequence 1110, 1101, 1011, 0111, each held exactly REFRESH_DIV cycles.
  - The scan is unaffected by CLR and inc.
- Segment data:
  - SEG shows the decode of the digit selected by the index.
  - SEG and AN are registered together, so they always change on the same edge; no ghosting cycle.
- Leading-zero blanking:
  - Digit i (i ≥ 1) shows blank (1111111) when it and all higher digits are zero.
  - Digit 0 is never blanked.
- Decode patterns (active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
- DP: low on digit 3 while OVF=1; high otherwise.
- Display latency: a count change appears on SEG the next time its digit is scanned, at the latest 4*REFRESH_DIV cycles later.

Decomposition:
- Shared package seq_det_pkg holds:
  - NUM_DIGITS=4;
  - the SEG_0..SEG_9 and SEG_BLANK patterns;
  - the AN reset value 1110.
- One combinational sub-module, seg7_decode: 4-bit BCD plus a blank flag in, 7-bit active-low SEG out. Non-BCD codes 10-15 decode to blank.
- The counter, synchroniser and scan logic stay in det_count_display.

Test Plan (REFRESH_DIV=4):
1. RST_N low for 3 cycles, released mid-cycle -> during reset AN=1110, SEG=1000000, DP=1, OVF=0. AN then steps 1110, 1101, 1011, 0111, each for exactly 4 CLK cycles, and repeats.
2. Three `detected` pulses (3 cycles high, 3 low) -> count 0003. Digit-0 slot SEG=0110000; digit-1..3 slots SEG=1111111. Each increment lands 2 edges after the first high sample.
3. `detected` held high for 50 cycles -> exactly one increment. Count 0001, digit 0 SEG=1111001.
4. 10000 pulses (3 high / 3 low) -> count 0000 and OVF=1 after the last pulse; DP=0 only in the AN=0111 slot. CLR for 1 cycle -> OVF=0, DP=1.
5. CLR asserted on the same edge as an inc pulse, from count 0012 -> count 0000; the event is not counted.
6. RST_N asserted asynchronously between CLK edges with count 0457 and index 2 -> immediately AN=1110, SEG=1000000, OVF=0. Count stays 0000 until the next `detected` event.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants for the detection-count display path:
//   - NUM_DIGITS / IDX_W : display width and digit-index width
//   - SEG_0..SEG_9, SEG_BLANK : active-low {g,f,e,d,c,b,a} patterns
//   - AN_RESET : anode pattern selecting digit 0 (active low)
//   - bcd_t : one BCD digit
//   - an_from_index() : active-low one-hot anode pattern for a digit index
// ----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [NUM_DIGITS-1:0] AN_RESET = 4'b1110;

    typedef logic [3:0] bcd_t;

    function automatic logic [NUM_DIGITS-1:0] an_from_index(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to seven-segment decoder, active-low outputs.
// Ports:
//   i_bcd   [3:0] : BCD digit; codes 10-15 decode to blank
//   i_blank       : force blank (leading-zero suppression)
//   o_seg   [6:0] : segments {g,f,e,d,c,b,a}, active low
// ----------------------------------------------------------------------------
module seg7_decode
    import seq_det_pkg::*;
(
    input  bcd_t       i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/det_count_display.sv
// ----------------------------------------------------------------------------
// det_count_display
// Counts detector events on a 4-digit BCD counter and drives a multiplexed
// 4-digit seven-segment display with leading-zero blanking and a sticky
// overflow flag shown on the digit-3 decimal point.
// Parameters:
//   REFRESH_DIV : CLK cycles each digit is displayed (2 .. 2^20)
// Ports:
//   CLK       : board clock
//   RST_N     : asynchronous active-low reset
//   detected  : detector output, asynchronous to CLK
//   CLR       : synchronous clear of count and OVF (active high)
//   SEG [6:0] : segments {g,f,e,d,c,b,a}, active low
//   DP        : decimal point, active low (lit on digit 3 while OVF)
//   AN  [3:0] : digit anodes, active-low one-hot, AN[0] = least significant
//   OVF       : sticky overflow flag
// ----------------------------------------------------------------------------
module det_count_display
    import seq_det_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
)
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  detected,
    input  logic                  CLR,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] AN,
    output logic                  OVF
);

    localparam int                CNT_W        = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  REFRESH_TERM = CNT_W'(REFRESH_DIV - 1);

    // ------------------------------------------------------------------
    // Synchroniser (s1, s2) plus history flop (s3) for rising-edge detect
    // ------------------------------------------------------------------
    logic r_s1, r_s2, r_s3;
    logic w_inc;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= detected;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_inc = r_s2 & ~r_s3;

    // ------------------------------------------------------------------
    // BCD counter. Carry into digit i is inc AND all lower digits at 9,
    // written flat rather than as a chain so there is no combinational
    // loop through a single vector.
    // ------------------------------------------------------------------
    bcd_t [NUM_DIGITS-1:0] r_digits;
    bcd_t [NUM_DIGITS-1:0] w_digits_next;
    logic [NUM_DIGITS-1:0] w_nine;
    logic [NUM_DIGITS:0]   w_carry;
    logic [NUM_DIGITS-1:1] w_zero_next;
    logic [NUM_DIGITS-1:0] w_blank_next;
    logic                  r_ovf;
    logic                  w_ovf_next;

    assign w_carry[0] = w_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nine[gi]        = (r_digits[gi] == 4'd9);
            assign w_carry[gi+1]     = w_inc & (&w_nine[gi:0]);
            assign w_digits_next[gi] = CLR          ? 4'd0 :
                                       !w_carry[gi] ? r_digits[gi] :
                                       w_nine[gi]   ? 4'd0 :
                                                      r_digits[gi] + 4'd1;

            // A digit is blank when it and every higher digit are zero;
            // the units digit always shows.
            if (gi == 0) begin : g_units
                assign w_blank_next[gi] = 1'b0;
            end else begin : g_upper
                assign w_zero_next[gi]  = (w_digits_next[gi] == 4'd0);
                assign w_blank_next[gi] = &w_zero_next[NUM_DIGITS-1:gi];
            end
        end
    endgenerate

    // CLR wins over both a pending inc and a wrap on the same edge.
    assign w_ovf_next = CLR ? 1'b0 : (r_ovf | w_carry[NUM_DIGITS]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_digits <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_digits <= w_digits_next;
            r_ovf    <= w_ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Scan: refresh prescaler and digit index, independent of CLR/inc
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_refresh;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_index_next;
    logic             w_term;

    assign w_term       = (r_refresh == REFRESH_TERM);
    assign w_index_next = w_term ? r_index + IDX_W'(1) : r_index;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_refresh <= '0;
            r_index   <= '0;
        end else begin
            r_refresh <= w_term ? '0 : r_refresh + CNT_W'(1);
            r_index   <= w_index_next;
        end
    end

    // ------------------------------------------------------------------
    // Display outputs. Segment data is decoded from the next-state count
    // and next index so SEG, AN and DP all load on the same edge and always
    // agree with the count/OVF registers.
    // ------------------------------------------------------------------
    bcd_t       w_sel_bcd;
    logic       w_sel_blank;
    logic [6:0] w_seg_next;

    assign w_sel_bcd   = w_digits_next[w_index_next];
    assign w_sel_blank = w_blank_next[w_index_next];

    seg7_decode u_seg7_decode (
        .i_bcd   (w_sel_bcd),
        .i_blank (w_sel_blank),
        .o_seg   (w_seg_next)
    );

    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_dp;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_seg <= SEG_0;
            r_an  <= AN_RESET;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= an_from_index(w_index_next);
            r_dp  <= ~((w_index_next == IDX_W'(NUM_DIGITS - 1)) & w_ovf_next);
        end
    end

    assign SEG = r_seg;
    assign AN  = r_an;
    assign DP  = r_dp;
    assign OVF = r_ovf;

endmodule

// File: tb/tb_det_count_display.sv
// ----------------------------------------------------------------------------
// tb_det_count_display
// Directed bench for det_count_display with REFRESH_DIV = 4. A reference
// count/overflow model plus a free-running scan-cycle counter give the
// expected AN, SEG and DP on every sampled cycle.
// ----------------------------------------------------------------------------
module tb_det_count_display;

    localparam int DIV    = 4;
    localparam int PERIOD = 4 * DIV;

    logic       CLK;
    logic       RST_N;
    logic       detected;
    logic       CLR;
    logic [6:0] SEG;
    logic       DP;
    logic [3:0] AN;
    logic       OVF;

    int n_checks = 0;
    int n_errors = 0;
    int m_count  = 0;
    bit m_ovf    = 0;
    int cyc;

    det_count_display #(.REFRESH_DIV(DIV)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .detected (detected),
        .CLR      (CLR),
        .SEG      (SEG),
        .DP       (DP),
        .AN       (AN),
        .OVF      (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Posedges since reset release; digit index after edge n is (n/4)%4.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b required %0b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        int p;
        p = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        if (idx > 0 && m_count < p) return 7'b1111111;
        return pat((m_count / p) % 10);
    endfunction

    function automatic logic [3:0] exp_an(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    task automatic m_inc();
        m_count++;
        if (m_count == 10000) begin
            m_count = 0;
            m_ovf   = 1'b1;
        end
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic pulse(input int hi, input int lo);
        detected = 1'b1;
        m_inc();
        repeat (hi) @(negedge CLK);
        detected = 1'b0;
        repeat (lo) @(negedge CLK);
    endtask

    task automatic clear();
        CLR = 1'b1;
        @(negedge CLK);
        CLR     = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_phase(input int p);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            @(negedge CLK);
            if (cyc % PERIOD == p) found = 1'b1;
        end
        if (!found) check("wait_phase", 32'd0, 32'd1);
    endtask

    // One full scan: AN against the scan model, SEG/DP against the count model.
    task automatic check_display(input string tag);
        int idx;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge CLK);
            idx = (cyc / DIV) % 4;
            check({tag, "_an"},  AN,  exp_an(idx));
            check({tag, "_seg"}, SEG, exp_seg(idx));
            check({tag, "_dp"},  DP,  (idx == 3 && m_ovf) ? 1'b0 : 1'b1);
        end
        check({tag, "_ovf"}, OVF, m_ovf);
        $display("display %s: count=%04d ovf=%0d", tag, m_count, m_ovf);
    endtask

    // Pulse launched at the start of the digit-0 slot so the increment
    // edge (two edges after the first high sample) is visible on SEG.
    task automatic pulse_aligned(input string tag);
        logic [6:0] old_seg;
        wait_phase(0);
        old_seg  = exp_seg(0);
        detected = 1'b1;
        @(negedge CLK);
        check({tag, "_k"}, SEG, old_seg);
        @(negedge CLK);
        check({tag, "_k1"}, SEG, old_seg);
        @(negedge CLK);
        m_inc();
        check({tag, "_k2"}, SEG, exp_seg(0));
        detected = 1'b0;
        repeat (3) @(negedge CLK);
        $display("pulse %s: count=%04d", tag, m_count);
    endtask

    initial begin
        RST_N    = 1'b0;
        detected = 1'b0;
        CLR      = 1'b0;

        // 1. Reset values and scan order
        repeat (3) @(posedge CLK);
        #1;
        check("rst_an",  AN,  4'b1110);
        check("rst_seg", SEG, 7'b1000000);
        check("rst_dp",  DP,  1'b1);
        check("rst_ovf", OVF, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        check("rel_an", AN, 4'b1110);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge CLK);
            check("scan_an", AN, exp_an((cyc / DIV) % 4));
        end
        $display("test1: reset and scan order done");

        // 2. Three pulses with increment latency
        for (int i = 0; i < 3; i++) pulse_aligned("t2_lat");
        check_display("t2");

        // 3. Long high level is one event
        clear();
        detected = 1'b1;
        m_inc();
        repeat (50) @(negedge CLK);
        detected = 1'b0;
        repeat (3) @(negedge CLK);
        check_display("t3");

        // 4. Wrap to 0000 with sticky OVF, then CLR
        clear();
        repeat (10000) pulse(3, 3);
        check("t4_ovf_set", OVF, 1'b1);
        check_display("t4_wrap");
        clear();
        check("t4_ovf_clr", OVF, 1'b0);
        check_display("t4_clr");

        // 5. CLR on the same edge as an increment loses the event
        clear();
        repeat (12) pulse(3, 3);
        check_display("t5_pre");
        detected = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR     = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        @(negedge CLK);
        detected = 1'b0;
        repeat (3) @(negedge CLK);
        check_display("t5_clr");
        pulse(3, 3);
        check_display("t5_after");

        // 6. Asynchronous reset mid-cycle from count 0457, index 2
        clear();
        repeat (457) pulse(3, 3);
        check_display("t6_pre");
        wait_phase(9);
        check("t6_an_idx2", AN, 4'b1011);
        #2;
        RST_N = 1'b0;
        #1;
        check("t6_async_an",  AN,  4'b1110);
        check("t6_async_seg", SEG, 7'b1000000);
        check("t6_async_ovf", OVF, 1'b0);
        check("t6_async_dp",  DP,  1'b1);
        m_count = 0;
        m_ovf   = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        check_display("t6_post");
        pulse(3, 3);
        check_display("t6_next");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
